// File: rtl/ysyx_25030093_mem_arbiter_if.sv
// Request/response bus shared by the IFU, LSU and memory sides of the arbiter.
interface ysyx_25030093_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] addr;
  logic              wen;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] rdata;
  logic              resp_err;

  // Requester side.
  modport master (
    output req_valid, addr, wen, wdata, wmask, resp_ready,
    input  req_ready, resp_valid, rdata, resp_err
  );

  // Responder side.
  modport slave (
    input  req_valid, addr, wen, wdata, wmask, resp_ready,
    output req_ready, resp_valid, rdata, resp_err
  );
endinterface

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one
// transaction in flight, with a response timeout that yields an error reply.
module ysyx_25030093_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_25030093_mem_arbiter_if.slave  ifu,
  ysyx_25030093_mem_arbiter_if.slave  lsu,
  ysyx_25030093_mem_arbiter_if.master mem
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REPLY} state_e;
  typedef enum logic {G_IFU = 1'b0, G_LSU = 1'b1} grant_e;

  state_e            state_q, state_d;
  grant_e            grant_q, grant_d;
  grant_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ifu_req_ready_c;
  logic              lsu_req_ready_c;
  logic              resp_hs_c;
  logic              unused_ifu_c;

  // IFU never writes; its write-side bus fields are ignored.
  assign unused_ifu_c = ^{ifu.wen, ifu.wdata, ifu.wmask};

  // Next-state and request-accept logic.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    ifu_req_ready_c = 1'b0;
    lsu_req_ready_c = 1'b0;
    resp_hs_c       = (grant_q == G_IFU) ? ifu.resp_ready : lsu.resp_ready;

    case (state_q)
      S_IDLE: begin
        if (ifu.req_valid && (!lsu.req_valid || last_q == G_LSU)) begin
          ifu_req_ready_c = 1'b1;
          grant_d         = G_IFU;
          addr_d          = ifu.addr;
          wen_d           = 1'b0;
          wdata_d         = '0;
          wmask_d         = '0;
          state_d         = S_ISSUE;
        end else if (lsu.req_valid) begin
          lsu_req_ready_c = 1'b1;
          grant_d         = G_LSU;
          addr_d          = lsu.addr;
          wen_d           = lsu.wen;
          wdata_d         = lsu.wdata;
          wmask_d         = lsu.wmask;
          state_d         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem.req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.resp_valid) begin
          rdata_d = wen_q ? '0 : mem.rdata;
          err_d   = mem.resp_err;
          state_d = S_REPLY;
        end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_REPLY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPLY: begin
        if (resp_hs_c) begin
          last_d  = grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      grant_q <= G_IFU;
      last_q  <= G_LSU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign ifu.req_ready  = ifu_req_ready_c;
  assign lsu.req_ready  = lsu_req_ready_c;
  assign ifu.resp_valid = (state_q == S_REPLY) && (grant_q == G_IFU);
  assign lsu.resp_valid = (state_q == S_REPLY) && (grant_q == G_LSU);
  assign ifu.rdata      = rdata_q;
  assign lsu.rdata      = rdata_q;
  assign ifu.resp_err   = err_q;
  assign lsu.resp_err   = err_q;

  assign mem.req_valid  = (state_q == S_ISSUE);
  assign mem.addr       = addr_q;
  assign mem.wen        = wen_q;
  assign mem.wdata      = wdata_q;
  assign mem.wmask      = wmask_q;
  assign mem.resp_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
endmodule
